axi_bram_slave: RTL

AXI_BRAM_SLAVE -- requirements
Module: axi_bram_slave

---
 rtl/axi_bram_slave_pkg.sv | 48 ++++
 rtl/axi_bram_slave_bram_sdp.sv | 43 ++++
 rtl/axi_bram_slave.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_bram_slave_pkg.sv
// Shared types and constants for the AXI BRAM slave.
// Holds FSM state enums, AXI encodings and the beat-error rule.
package axi_bram_slave_pkg;

  localparam int ID_WIDTH_DEF = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_e;

  // Any beat that cannot map onto a whole BRAM word is an error.
  function automatic logic beat_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] depth,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) ||
           (addr < base)        ||
           (idx >= depth)       ||
           (size != 3'd2)       ||
           burst[1];
  endfunction

  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic [1:0]  burst
  );
    return (burst == AXI_BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/axi_bram_slave_bram_sdp.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
// The read register clears on reset or on request for error beats.
module bram_sdp #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_re,
  input  logic          i_rclr,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Non-blocking read of the array gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= 32'h0;
    end else if (i_re) begin
      r_q <= i_rclr ? 32'h0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_bram_slave.sv
// AXI4 slave over an internal BRAM with independent
// write and read burst FSMs.
module axi_bram_slave
  import axi_bram_slave_pkg::*;
#(
  parameter int          ID_WIDTH    = ID_WIDTH_DEF,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] axi_awid,
  input  logic [31:0]         axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic [3:0]          axi_awqos,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [31:0]         axi_wdata,
  input  logic [3:0]          axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_WIDTH-1:0] axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ID_WIDTH-1:0] axi_arid,
  input  logic [31:0]         axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic [3:0]          axi_arqos,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_WIDTH-1:0] axi_rid,
  output logic [31:0]         axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  wr_state_e           r_wst;
  logic [ID_WIDTH-1:0] r_bid;
  logic [31:0]         r_waddr;
  logic [7:0]          r_wlen;
  logic [7:0]          r_wcnt;
  logic [2:0]          r_wsize;
  logic [1:0]          r_wburst;
  logic                r_werr;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;

  rd_state_e           r_rst;
  logic [ID_WIDTH-1:0] r_rid;
  logic [31:0]         r_raddr;
  logic [7:0]          r_rlen;
  logic [7:0]          r_rcnt;
  logic [2:0]          r_rsize;
  logic [1:0]          r_rburst;
  logic                r_arready;
  logic                r_rvalid;
  logic                r_rlast;
  logic [1:0]          r_rresp;

  logic                w_wbeat;
  logic                w_wbad;
  logic                w_we;
  logic [31:0]         w_woff;
  logic                w_re;
  logic                w_rbad;
  logic [31:0]         w_roff;
  logic [31:0]         w_rdata;

  assign w_wbeat = (r_wst == W_DATA) && r_wready && axi_wvalid;
  assign w_wbad  = beat_err(r_waddr, BASE_ADDR, DEPTH,
                            r_wsize, r_wburst);
  assign w_we    = w_wbeat && !w_wbad;
  assign w_woff  = r_waddr - BASE_ADDR;

  assign w_re    = (r_rst == R_FETCH);
  assign w_rbad  = beat_err(r_raddr, BASE_ADDR, DEPTH,
                            r_rsize, r_rburst);
  assign w_roff  = r_raddr - BASE_ADDR;

  bram_sdp #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_woff[AW+1:2]),
    .i_wdata (axi_wdata),
    .i_wstrb (axi_wstrb),
    .i_re    (w_re),
    .i_rclr  (w_rbad),
    .i_raddr (w_roff[AW+1:2]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wst     <= W_IDLE;
      r_bid     <= '0;
      r_waddr   <= 32'h0;
      r_wlen    <= 8'h0;
      r_wcnt    <= 8'h0;
      r_wsize   <= 3'h0;
      r_wburst  <= 2'h0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && axi_awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= axi_awid;
            r_waddr   <= axi_awaddr;
            r_wlen    <= axi_awlen;
            r_wsize   <= axi_awsize;
            r_wburst  <= axi_awburst;
            r_wcnt    <= 8'h0;
            r_werr    <= 1'b0;
            r_wst     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= next_addr(r_waddr, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            if (w_wbad) r_werr <= 1'b1;
            // Length, not wlast, closes the burst.
            if (r_wcnt == r_wlen) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_wbad) ?
                          AXI_RESP_SLVERR : AXI_RESP_OKAY;
              r_wst    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rst     <= R_IDLE;
      r_rid     <= '0;
      r_raddr   <= 32'h0;
      r_rlen    <= 8'h0;
      r_rcnt    <= 8'h0;
      r_rsize   <= 3'h0;
      r_rburst  <= 2'h0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= AXI_RESP_OKAY;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (r_arready && axi_arvalid) begin
            r_arready <= 1'b0;
            r_rid     <= axi_arid;
            r_raddr   <= axi_araddr;
            r_rlen    <= axi_arlen;
            r_rsize   <= axi_arsize;
            r_rburst  <= axi_arburst;
            r_rcnt    <= 8'h0;
            r_rst     <= R_FETCH;
          end
        end
        R_FETCH: begin
          r_rvalid <= 1'b1;
          r_rlast  <= (r_rcnt == r_rlen);
          r_rresp  <= w_rbad ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          r_rst    <= R_DATA;
        end
        R_DATA: begin
          if (axi_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_rst     <= R_IDLE;
            end else begin
              r_raddr <= next_addr(r_raddr, r_rburst);
              r_rcnt  <= r_rcnt + 8'd1;
              r_rst   <= R_FETCH;
            end
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  assign axi_awready = r_awready;
  assign axi_wready  = r_wready;
  assign axi_bvalid  = r_bvalid;
  assign axi_bresp   = r_bresp;
  assign axi_bid     = r_bid;
  assign axi_arready = r_arready;
  assign axi_rvalid  = r_rvalid;
  assign axi_rlast   = r_rlast;
  assign axi_rresp   = r_rresp;
  assign axi_rid     = r_rid;
  assign axi_rdata   = w_rdata;

  logic w_unused;
  assign w_unused = ^{axi_awlock, axi_awcache, axi_awprot,
                      axi_awqos, axi_arlock, axi_arcache,
                      axi_arprot, axi_arqos, axi_wlast,
                      w_woff, w_roff};

endmodule
